channel_responder: RTL and testbench

- Device-side responder for the parallel channel bus-and-tag interface. It is the control-unit end that connects to the device port of the channel tee.
- Recognises its address during initial selection, raises operational/address in, captures the command byte and presents a status byte.
- Passes selection on to the next unit when it is not addressed.
- Supports command/status-only operations; no data transfer (service_in and request_in are held low).

---
 rtl/channel_responder.sv | 220 ++++++++++++++++++++++
 tb/tb_channel_responder.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_responder.sv
`default_nettype none
// ============================================================================
// Module   : channel_responder
// Brief    : Control-unit end of the channel bus-and-tag interface. Answers
//            initial selection, takes one command byte, presents one status.
// Revision : 1.0 - initial release
// ============================================================================
module channel_responder #(
    parameter logic [7:0]  ADDRESS      = 8'hE0,
    parameter logic [7:0]  ADDRESS_MASK = 8'hFF,
    parameter int unsigned SETTLE       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] bus_out,
    input  logic       bus_out_parity,
    input  logic       operational_out,
    input  logic       hold_out,
    input  logic       address_out,
    input  logic       command_out,
    input  logic       service_out,
    input  logic       suppress_out,
    input  logic       selection_x,
    output logic [7:0] bus_in,
    output logic       bus_in_parity,
    output logic       operational_in,
    output logic       request_in,
    output logic       address_in,
    output logic       status_in,
    output logic       service_in,
    output logic       selection_y,
    output logic       cmd_strobe,
    output logic [7:0] cmd,
    output logic       cmd_parity_error,
    input  logic       status_valid,
    input  logic [7:0] status,
    output logic       status_done,
    output logic       status_stacked,
    output logic       abort
);

    typedef enum logic [3:0] {
        S_IDLE          = 4'd0,
        S_PASS          = 4'd1,
        S_SETTLE_ADDR   = 4'd2,
        S_ADDR_IN       = 4'd3,
        S_CMD           = 4'd4,
        S_WAIT_STATUS   = 4'd5,
        S_SETTLE_STATUS = 4'd6,
        S_STATUS_IN     = 4'd7,
        S_DISC          = 4'd8
    } state_t;

    localparam logic [7:0] c_settle_load = 8'(SETTLE);

    state_t     r_state, w_state_next;
    logic [7:0] r_count, w_count_next;
    logic [7:0] w_bus_in_next, w_cmd_next;
    logic       w_op_in_next, w_addr_in_next, w_status_in_next, w_sel_y_next;
    logic       w_cmd_perr_next, w_strobe_next, w_done_next, w_stacked_next;
    logic       w_abort_next, w_match, w_drop;
    logic       w_unused_tags;

    assign w_unused_tags = hold_out ^ suppress_out;
    assign request_in    = 1'b0;
    assign service_in    = 1'b0;

    assign w_match = ((bus_out & ADDRESS_MASK) == (ADDRESS & ADDRESS_MASK));

    // Losing operational out, or select before the command arrives, ends the connection.
    assign w_drop = (r_state != S_IDLE) && (r_state != S_PASS) &&
                    (!operational_out ||
                     (!selection_x && (r_state == S_SETTLE_ADDR || r_state == S_ADDR_IN)));

    always_comb begin
        w_state_next     = r_state;
        w_count_next     = r_count;
        w_bus_in_next    = bus_in;
        w_op_in_next     = operational_in;
        w_addr_in_next   = address_in;
        w_status_in_next = status_in;
        w_sel_y_next     = selection_y;
        w_cmd_next       = cmd;
        w_cmd_perr_next  = cmd_parity_error;
        w_strobe_next    = 1'b0;
        w_done_next      = 1'b0;
        w_stacked_next   = 1'b0;
        w_abort_next     = 1'b0;

        if (w_drop) begin
            w_state_next     = S_IDLE;
            w_bus_in_next    = 8'h00;
            w_op_in_next     = 1'b0;
            w_addr_in_next   = 1'b0;
            w_status_in_next = 1'b0;
            w_sel_y_next     = 1'b0;
            w_abort_next     = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (selection_x) begin
                        if (address_out && operational_out && w_match) begin
                            w_state_next  = S_SETTLE_ADDR;
                            w_bus_in_next = ADDRESS;
                            w_op_in_next  = 1'b1;
                            w_count_next  = c_settle_load;
                        end else begin
                            w_state_next = S_PASS;
                            w_sel_y_next = 1'b1;
                        end
                    end
                end
                S_PASS: begin
                    if (!selection_x || !operational_out) begin
                        w_state_next = S_IDLE;
                        w_sel_y_next = 1'b0;
                    end
                end
                S_SETTLE_ADDR: begin
                    if (r_count <= 8'd1) begin
                        w_state_next   = S_ADDR_IN;
                        w_addr_in_next = 1'b1;
                    end else begin
                        w_count_next = r_count - 8'd1;
                    end
                end
                S_ADDR_IN: begin
                    if (command_out) begin
                        w_state_next    = S_CMD;
                        w_cmd_next      = bus_out;
                        w_cmd_perr_next = ~(^{bus_out, bus_out_parity});
                        w_addr_in_next  = 1'b0;
                        w_bus_in_next   = 8'h00;
                    end
                end
                S_CMD: begin
                    if (!command_out) begin
                        w_state_next  = S_WAIT_STATUS;
                        w_strobe_next = 1'b1;
                    end
                end
                S_WAIT_STATUS: begin
                    if (status_valid) begin
                        w_state_next  = S_SETTLE_STATUS;
                        w_bus_in_next = status;
                        w_count_next  = c_settle_load;
                    end
                end
                S_SETTLE_STATUS: begin
                    if (r_count <= 8'd1) begin
                        w_state_next     = S_STATUS_IN;
                        w_status_in_next = 1'b1;
                    end else begin
                        w_count_next = r_count - 8'd1;
                    end
                end
                S_STATUS_IN: begin
                    // Service out takes precedence when both tags rise together.
                    if (service_out) begin
                        w_state_next     = S_DISC;
                        w_status_in_next = 1'b0;
                        w_bus_in_next    = 8'h00;
                        w_done_next      = 1'b1;
                    end else if (command_out) begin
                        w_state_next     = S_DISC;
                        w_status_in_next = 1'b0;
                        w_bus_in_next    = 8'h00;
                        w_stacked_next   = 1'b1;
                    end
                end
                S_DISC: begin
                    w_bus_in_next = 8'h00;
                    if (!service_out && !command_out && !selection_x) begin
                        w_state_next = S_IDLE;
                        w_op_in_next = 1'b0;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_count          <= 8'h00;
            bus_in           <= 8'h00;
            bus_in_parity    <= 1'b0;
            operational_in   <= 1'b0;
            address_in       <= 1'b0;
            status_in        <= 1'b0;
            selection_y      <= 1'b0;
            cmd              <= 8'h00;
            cmd_parity_error <= 1'b0;
            cmd_strobe       <= 1'b0;
            status_done      <= 1'b0;
            status_stacked   <= 1'b0;
            abort            <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_count          <= w_count_next;
            bus_in           <= w_bus_in_next;
            bus_in_parity    <= ~^w_bus_in_next;
            operational_in   <= w_op_in_next;
            address_in       <= w_addr_in_next;
            status_in        <= w_status_in_next;
            selection_y      <= w_sel_y_next;
            cmd              <= w_cmd_next;
            cmd_parity_error <= w_cmd_perr_next;
            cmd_strobe       <= w_strobe_next;
            status_done      <= w_done_next;
            status_stacked   <= w_stacked_next;
            abort            <= w_abort_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_channel_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_channel_responder
// Brief    : Randomized channel-side sequences against a timeline model of the
//            responder; expected tags and bytes come from each sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_channel_responder;

    localparam logic [7:0] c_address = 8'hE0;
    localparam int         c_settle  = 4;

    logic       clk;
    logic       reset;
    logic [7:0] bus_out;
    logic       bus_out_parity;
    logic       operational_out, hold_out, address_out, command_out;
    logic       service_out, suppress_out, selection_x;
    logic [7:0] bus_in;
    logic       bus_in_parity, operational_in, request_in, address_in;
    logic       status_in, service_in, selection_y, cmd_strobe;
    logic [7:0] cmd;
    logic       cmd_parity_error;
    logic       status_valid;
    logic [7:0] status;
    logic       status_done, status_stacked, abort;

    int         assert_count;
    int         fail_count;
    logic [7:0] exp_cmd;
    logic       exp_perr;

    channel_responder #(
        .ADDRESS      (c_address),
        .ADDRESS_MASK (8'hFF),
        .SETTLE       (c_settle)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .bus_out          (bus_out),
        .bus_out_parity   (bus_out_parity),
        .operational_out  (operational_out),
        .hold_out         (hold_out),
        .address_out      (address_out),
        .command_out      (command_out),
        .service_out      (service_out),
        .suppress_out     (suppress_out),
        .selection_x      (selection_x),
        .bus_in           (bus_in),
        .bus_in_parity    (bus_in_parity),
        .operational_in   (operational_in),
        .request_in       (request_in),
        .address_in       (address_in),
        .status_in        (status_in),
        .service_in       (service_in),
        .selection_y      (selection_y),
        .cmd_strobe       (cmd_strobe),
        .cmd              (cmd),
        .cmd_parity_error (cmd_parity_error),
        .status_valid     (status_valid),
        .status           (status),
        .status_done      (status_done),
        .status_stacked   (status_stacked),
        .abort            (abort)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_count++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // e_tags = {operational_in, address_in, status_in, selection_y}
    // e_pulses = {cmd_strobe, status_done, status_stacked, abort}
    task automatic check_outs(input string tag, input logic [3:0] e_tags,
                              input logic [7:0] e_bus, input logic [3:0] e_pulses);
        check_value({tag, ".tags"}, 32'({operational_in, address_in, status_in, selection_y}), 32'(e_tags));
        check_value({tag, ".pulses"}, 32'({cmd_strobe, status_done, status_stacked, abort}), 32'(e_pulses));
        check_value({tag, ".bus"}, 32'(bus_in), 32'(e_bus));
        check_value({tag, ".par"}, 32'(bus_in_parity), 32'(~^e_bus));
        check_value({tag, ".rqsv"}, 32'({request_in, service_in}), 32'(0));
        check_value({tag, ".cmd"}, 32'({cmd, cmd_parity_error}), 32'({exp_cmd, exp_perr}));
    endtask

    task automatic check_idle(input string tag);
        check_outs(tag, 4'b0000, 8'h00, 4'b0000);
    endtask

    task automatic check_all_zero(input string tag);
        check_value(tag, 32'({bus_in, bus_in_parity, operational_in, request_in, address_in,
                              status_in, service_in, selection_y, cmd_strobe, cmd,
                              cmd_parity_error, status_done, status_stacked, abort}), 32'(0));
    endtask

    task automatic idle_inputs();
        address_out  = 1'b0;
        command_out  = 1'b0;
        service_out  = 1'b0;
        selection_x  = 1'b0;
        status_valid = 1'b0;
        operational_out = 1'b1;
    endtask

    task automatic do_abort(input logic drop_sel);
        if (drop_sel) selection_x = 1'b0;
        else          operational_out = 1'b0;
        cyc();
        check_outs("abort", 4'b0000, 8'h00, 4'b0001);
        idle_inputs();
        cyc();
        check_idle("post_abort");
    endtask

    task automatic async_reset_check();
        #3;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        idle_inputs();
        exp_cmd  = 8'h00;
        exp_perr = 1'b0;
        #1;
        reset = 1'b0;
        cyc();
        check_idle("after_reset");
    endtask

    // ab: 0 none, 1 select drop while settling, 2 select drop at address in,
    // 3..7 operational drop at address in / command / wait / settle / status in,
    // 8 asynchronous reset at address in. fin: 0 service, 1 command, 2 both.
    task automatic run_addressed(input int ab, input logic [7:0] cb, input logic cp,
                                 input logic [7:0] sb, input int fin);
        int drop_k;
        drop_k = int'($urandom_range(1, c_settle));
        operational_out = 1'b1;
        bus_out         = c_address;
        bus_out_parity  = ~^c_address;
        address_out     = 1'b1;
        selection_x     = 1'b1;
        for (int k = 1; k <= c_settle; k++) begin
            cyc();
            address_out = 1'b0;
            bus_out     = 8'($urandom);
            check_outs("settle_addr", 4'b1000, c_address, 4'b0000);
            if (ab == 1 && k == drop_k) begin
                do_abort(1'b1);
                return;
            end
        end
        cyc();
        check_outs("addr_in", 4'b1100, c_address, 4'b0000);
        repeat ($urandom_range(0, 2)) begin
            cyc();
            check_outs("addr_in_hold", 4'b1100, c_address, 4'b0000);
        end
        if (ab == 8) begin async_reset_check(); return; end
        if (ab == 2) begin do_abort(1'b1); return; end
        if (ab == 3) begin do_abort(1'b0); return; end

        bus_out        = cb;
        bus_out_parity = cp;
        command_out    = 1'b1;
        cyc();
        exp_cmd  = cb;
        exp_perr = ~(^{cb, cp});
        check_outs("cmd_cap", 4'b1000, 8'h00, 4'b0000);
        if (ab == 4) begin do_abort(1'b0); return; end
        repeat ($urandom_range(0, 2)) begin
            cyc();
            check_outs("cmd_hold", 4'b1000, 8'h00, 4'b0000);
        end
        command_out = 1'b0;
        bus_out     = 8'($urandom);
        cyc();
        check_outs("cmd_strobe", 4'b1000, 8'h00, 4'b1000);
        repeat ($urandom_range(0, 2)) begin
            cyc();
            check_outs("wait_status", 4'b1000, 8'h00, 4'b0000);
        end
        if (ab == 5) begin do_abort(1'b0); return; end

        status       = sb;
        status_valid = 1'b1;
        cyc();
        check_outs("status_load", 4'b1000, sb, 4'b0000);
        if (ab == 6) begin do_abort(1'b0); return; end
        for (int k = 2; k <= c_settle; k++) begin
            cyc();
            check_outs("settle_status", 4'b1000, sb, 4'b0000);
        end
        cyc();
        check_outs("status_in", 4'b1010, sb, 4'b0000);
        repeat ($urandom_range(0, 2)) begin
            cyc();
            check_outs("status_hold", 4'b1010, sb, 4'b0000);
        end
        if (ab == 7) begin do_abort(1'b0); return; end

        service_out = (fin != 1);
        command_out = (fin != 0);
        cyc();
        status_valid = 1'b0;
        status       = 8'($urandom);
        check_outs("status_end", 4'b1000, 8'h00, (fin != 1) ? 4'b0100 : 4'b0010);
        repeat ($urandom_range(0, 2)) begin
            cyc();
            check_outs("disc_hold", 4'b1000, 8'h00, 4'b0000);
        end
        service_out = 1'b0;
        command_out = 1'b0;
        cyc();
        check_outs("disc_sel", 4'b1000, 8'h00, 4'b0000);
        selection_x = 1'b0;
        cyc();
        check_idle("disc_done");
    endtask

    task automatic run_pass();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == c_address || $urandom_range(0, 1) == 1) begin
            bus_out     = c_address;
            address_out = 1'b0;
        end else begin
            bus_out     = b;
            address_out = 1'b1;
        end
        operational_out = 1'b1;
        selection_x     = 1'b1;
        cyc();
        check_outs("pass", 4'b0001, 8'h00, 4'b0000);
        repeat ($urandom_range(1, 3)) begin
            bus_out     = c_address;
            address_out = 1'b1;
            cyc();
            check_outs("pass_hold", 4'b0001, 8'h00, 4'b0000);
        end
        if ($urandom_range(0, 1) == 1) begin
            operational_out = 1'b0;
            cyc();
            check_idle("pass_opdrop");
            selection_x     = 1'b0;
            operational_out = 1'b1;
        end else begin
            selection_x = 1'b0;
        end
        address_out = 1'b0;
        cyc();
        check_idle("pass_end");
    endtask

    initial begin
        int kind;
        assert_count    = 0;
        fail_count      = 0;
        exp_cmd         = 8'h00;
        exp_perr        = 1'b0;
        reset           = 1'b0;
        bus_out         = 8'h00;
        bus_out_parity  = 1'b0;
        operational_out = 1'b0;
        hold_out        = 1'b0;
        address_out     = 1'b0;
        command_out     = 1'b0;
        service_out     = 1'b0;
        suppress_out    = 1'b0;
        selection_x     = 1'b0;
        status_valid    = 1'b0;
        status          = 8'h00;
        #2;
        reset = 1'b1;
        #2;
        check_all_zero("reset_state");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        operational_out = 1'b1;
        cyc();
        check_idle("idle");

        run_addressed(0, 8'h01, 1'b0, 8'h0C, 0);
        run_addressed(0, 8'h5A, 1'b1, 8'h0C, 1);
        run_addressed(0, 8'h03, 1'b0, 8'h40, 2);
        run_pass();
        for (int a = 1; a <= 7; a++) begin
            run_addressed(a, 8'($urandom), 1'($urandom), 8'($urandom), 0);
        end

        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 9));
            hold_out     = 1'($urandom);
            suppress_out = 1'($urandom);
            if (kind >= 7)
                run_pass();
            else if (kind >= 4)
                run_addressed(int'($urandom_range(1, 7)), 8'($urandom), 1'($urandom),
                              8'($urandom), int'($urandom_range(0, 2)));
            else
                run_addressed(0, 8'($urandom), 1'($urandom), 8'($urandom),
                              int'($urandom_range(0, 2)));
            repeat ($urandom_range(0, 2)) begin
                cyc();
                check_idle("gap");
            end
        end

        run_addressed(8, 8'h22, 1'b0, 8'h00, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
`default_nettype wire
